// File: rtl/simple_circuit_pipe_if.sv
// rtl/simple_circuit_pipe_if.sv - beat input/result output handshake bundle for simple_circuit_pipe
interface simple_circuit_pipe_if #(
  parameter int WIDTH = 4
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic [1:0]                   mode;
  logic [WIDTH-1:0]             a;
  logic [WIDTH-1:0]             b;
  logic [WIDTH-1:0]             c;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             f;
  logic [$clog2(WIDTH+1)-1:0]   ones;

  modport slave (
    input  in_valid, mode, a, b, c, out_ready,
    output in_ready, out_valid, f, ones
  );

  modport master (
    output in_valid, mode, a, b, c, out_ready,
    input  in_ready, out_valid, f, ones
  );
endinterface

// File: rtl/simple_circuit_pipe.sv
// rtl/simple_circuit_pipe.sv - per-bit logic function with popcount, elastic STAGES-deep pipeline and transfer counter
module simple_circuit_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  simple_circuit_pipe_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     xfer_cnt
);
  localparam int OW = $clog2(WIDTH+1);

  logic [WIDTH-1:0]  fn;
  logic [OW-1:0]     fn_ones;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_vld;
  logic [WIDTH-1:0]  dat      [STAGES];
  logic [OW-1:0]     ones_q   [STAGES];
  logic [WIDTH-1:0]  src_dat  [STAGES];
  logic [OW-1:0]     src_ones [STAGES];
  logic              xfer;

  always_comb begin
    case (bus.mode)
      2'd0:    fn = (bus.a & bus.b) | ~bus.c;
      2'd1:    fn = (bus.a | bus.b) & ~bus.c;
      2'd2:    fn = bus.a ^ bus.b ^ bus.c;
      default: fn = ~((bus.a & bus.b) | bus.c);
    endcase
    fn_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fn_ones = fn_ones + OW'(fn[i]);
    end
  end

  // A stage may load when it is empty or everything downstream of it can move,
  // so room ripples back from out_ready through each full stage.
  always_comb begin : ready_chain
    logic room;
    room = bus.out_ready;
    for (int k = STAGES-1; k >= 0; k--) begin
      room    = ~vld[k] | room;
      load[k] = room;
    end
  end

  always_comb begin
    src_vld[0]  = bus.in_valid;
    src_dat[0]  = fn;
    src_ones[0] = fn_ones;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k]  = vld[k-1];
      src_dat[k]  = dat[k-1];
      src_ones[k] = ones_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat[k]    <= '0;
        ones_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld[k]    <= src_vld[k];
          dat[k]    <= src_dat[k];
          ones_q[k] <= src_ones[k];
        end
      end
    end
  end

  assign xfer = vld[STAGES-1] & bus.out_ready;

  // Clear wins over a same-cycle transfer; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (cnt_clr) begin
      xfer_cnt <= '0;
    end else if (xfer && !(&xfer_cnt)) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.f         = dat[STAGES-1];
  assign bus.ones      = ones_q[STAGES-1];
endmodule
